// File: rtl/picoblaze_irq_ctrl.sv
// Interrupt controller for KCPSM6: turns tick pulses into one held request per event,
// counts ticks dropped while a request is outstanding, and keeps seconds/heartbeat state.
module picoblaze_irq_ctrl #(
    parameter int HOLDOFF    = 4,
    parameter int SEC_WIDTH  = 16,
    parameter int MISS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick_in,
    input  logic                  irq_enable,
    input  logic                  interrupt_ack,
    input  logic                  clr_stat,
    output logic                  interrupt,
    output logic [SEC_WIDTH-1:0]  seconds,
    output logic [MISS_WIDTH-1:0] missed,
    output logic                  heartbeat_led
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    localparam logic [7:0]            CNT_LOAD = 8'(HOLDOFF - 1);
    localparam logic [SEC_WIDTH-1:0]  SEC_ONE  = 1;
    localparam logic [MISS_WIDTH-1:0] MISS_ONE = 1;

    state_t                state_q, state_d;
    logic                  tick_d_q, tick_d_d;
    logic                  queued_q, queued_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [SEC_WIDTH-1:0]  seconds_q, seconds_d;
    logic [MISS_WIDTH-1:0] missed_q, missed_d;
    logic                  hb_q, hb_d;
    logic                  irq_q, irq_d;
    logic                  ev;
    logic                  miss_inc;

    always_comb begin
        ev        = tick_in & ~tick_d_q;
        tick_d_d  = tick_in;
        seconds_d = seconds_q;
        hb_d      = hb_q;
        state_d   = state_q;
        queued_d  = queued_q;
        cnt_d     = cnt_q;
        miss_inc  = 1'b0;
        missed_d  = missed_q;

        if (ev) begin
            seconds_d = seconds_q + SEC_ONE;
            hb_d      = ~hb_q;
        end

        case (state_q)
            S_IDLE: begin
                if (ev) state_d = S_ASSERT;
            end
            S_ASSERT: begin
                // A tick arriving with the ack is deferred, not dropped.
                if (interrupt_ack) begin
                    state_d  = S_HOLD;
                    cnt_d    = CNT_LOAD;
                    queued_d = ev;
                end else if (ev) begin
                    miss_inc = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
                if (ev) begin
                    if (queued_q) miss_inc = 1'b1;
                    else          queued_d = 1'b1;
                end
                if (cnt_q == 8'd0) begin
                    state_d  = queued_d ? S_ASSERT : S_IDLE;
                    queued_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Disabling withdraws everything; nothing dropped here counts as missed.
        if (!irq_enable) begin
            state_d  = S_IDLE;
            queued_d = 1'b0;
            miss_inc = 1'b0;
        end

        if (clr_stat)
            missed_d = '0;
        else if (miss_inc && (missed_q != {MISS_WIDTH{1'b1}}))
            missed_d = missed_q + MISS_ONE;

        irq_d = (state_d == S_ASSERT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            tick_d_q  <= 1'b0;
            queued_q  <= 1'b0;
            cnt_q     <= 8'd0;
            seconds_q <= '0;
            missed_q  <= '0;
            hb_q      <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_d_q  <= tick_d_d;
            queued_q  <= queued_d;
            cnt_q     <= cnt_d;
            seconds_q <= seconds_d;
            missed_q  <= missed_d;
            hb_q      <= hb_d;
            irq_q     <= irq_d;
        end
    end

    assign interrupt     = irq_q;
    assign seconds       = seconds_q;
    assign missed        = missed_q;
    assign heartbeat_led = hb_q;

endmodule

// File: tb/tb_picoblaze_irq_ctrl.sv
// Directed bench for picoblaze_irq_ctrl: the driver pushes hand-computed expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_picoblaze_irq_ctrl;

    localparam int SW = 4;
    localparam int MW = 8;
    localparam int W  = 1 + SW + MW + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          tick_in;
    logic          irq_enable;
    logic          interrupt_ack;
    logic          clr_stat;
    logic          interrupt;
    logic [SW-1:0] seconds;
    logic [MW-1:0] missed;
    logic          heartbeat_led;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           exp_sec = 0;
    logic         exp_hb  = 1'b0;

    picoblaze_irq_ctrl #(.HOLDOFF(4), .SEC_WIDTH(SW), .MISS_WIDTH(MW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick_in       (tick_in),
        .irq_enable    (irq_enable),
        .interrupt_ack (interrupt_ack),
        .clr_stat      (clr_stat),
        .interrupt     (interrupt),
        .seconds       (seconds),
        .missed        (missed),
        .heartbeat_led (heartbeat_led)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] g;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = {interrupt, seconds, missed, heartbeat_led};
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s: got irq=%0b sec=%0d missed=%0d hb=%0b, expected irq=%0b sec=%0d missed=%0d hb=%0b",
                         nm, g[W-1], g[W-2 -: SW], g[MW:1], g[0],
                         e[W-1], e[W-2 -: SW], e[MW:1], e[0]);
            end
        end
    end

    // driver tasks
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string nm, input logic irq, input logic [MW-1:0] mis);
        exp_q.push_back({irq, 4'(exp_sec), mis, exp_hb});
        name_q.push_back(nm);
    endtask

    // Rising edge sampled at the next clock edge; tick_in is dropped afterwards.
    task automatic tick();
        tick_in = 1'b1;
        step();
        exp_sec = exp_sec + 1;
        exp_hb  = ~exp_hb;
        tick_in = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        tick_in       = 1'b0;
        irq_enable    = 1'b0;
        interrupt_ack = 1'b0;
        clr_stat      = 1'b0;
        step(3);
        expect_out("reset_values", 1'b0, 8'd0);
        reset_n    = 1'b1;
        irq_enable = 1'b1;
        step(5);

        // long tick pulse: one event only
        tick_in = 1'b1;
        step();
        exp_sec = exp_sec + 1;
        exp_hb  = ~exp_hb;
        expect_out("first_assert", 1'b1, 8'd0);
        step(2);
        expect_out("held_tick_no_dup", 1'b1, 8'd0);
        tick_in = 1'b0;
        step(3);

        // ack, holdoff, back to idle, fresh tick
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        expect_out("holdoff_m1", 1'b0, 8'd0);
        step(3);
        expect_out("holdoff_m4", 1'b0, 8'd0);
        step();
        expect_out("idle_after_holdoff", 1'b0, 8'd0);
        step(3);
        tick();
        expect_out("retick_assert", 1'b1, 8'd0);
        step();

        // tick while asserted is missed
        tick();
        expect_out("missed_in_assert", 1'b1, 8'd1);
        step();

        // ack, two ticks during holdoff: one queued, one missed
        interrupt_ack = 1'b1;
        tick_in       = 1'b0;
        step();
        interrupt_ack = 1'b0;
        expect_out("ack_drop", 1'b0, 8'd1);
        tick();
        expect_out("queued_tick", 1'b0, 8'd1);
        step();
        tick();
        expect_out("second_holdoff_tick", 1'b0, 8'd2);
        step();
        expect_out("queued_reassert", 1'b1, 8'd2);
        step();

        // tick and ack in the same cycle
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        expect_out("tick_ack_same", 1'b0, 8'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("same_holdoff_low", 1'b0, 8'd2);
        end
        step();
        expect_out("same_reassert", 1'b1, 8'd2);
        step();

        // saturation of missed
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 252) expect_out("missed_reach_max", 1'b1, 8'd255);
            step();
        end
        expect_out("missed_saturated", 1'b1, 8'd255);
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        expect_out("clr_wins", 1'b1, 8'd0);
        step();

        // disabled: counters only, seconds wraps at 16
        irq_enable = 1'b0;
        step();
        expect_out("disable_withdraw", 1'b0, 8'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            if ((exp_sec % 16) == 0) expect_out("sec_wrap", 1'b0, 8'd0);
            else                     expect_out("disabled_tick", 1'b0, 8'd0);
            step();
        end

        // async reset during a request
        irq_enable = 1'b1;
        tick();
        expect_out("pre_reset_assert", 1'b1, 8'd0);
        step();
        reset_n = 1'b0;
        #1;
        exp_sec = 0;
        exp_hb  = 1'b0;
        expect_out("async_reset_drop", 1'b0, 8'd0);
        step(2);
        reset_n = 1'b1;
        step(3);

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
